// File: rtl/adaptive_thr_pkg.sv
// Shared widths, frame-size defaults, the S1 stage record and the threshold clamp
// used when ADAPTIVE_BINARIZER_OFFSET_EN is defined.
package adaptive_thr_pkg;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 8;
    localparam int DEF_COLS = 256;
    localparam int DEF_ROWS = 256;

    typedef struct packed {
        logic              valid;
        logic [PIX_W-1:0]  pixel;
        logic [ADDR_W-1:0] col;
        logic [ADDR_W-1:0] row;
        logic              eol;
        logic              eof;
    } s1_rec_t;

    // Ten bits hold both 255 - (-128) and 0 - 127 without wrapping.
    function automatic logic [PIX_W-1:0] clamp_thr(input logic [PIX_W-1:0] thr,
                                                   input logic [PIX_W-1:0] offset);
        logic signed [9:0] diff;
        diff = $signed({2'b00, thr}) - $signed({{2{offset[PIX_W-1]}}, offset});
        if (diff < 10'sd0) return '0;
        if (diff > 10'sd255) return '1;
        return diff[PIX_W-1:0];
    endfunction
endpackage

// File: rtl/adaptive_binarizer_if.sv
// Pixel input stream and binarized output stream of the adaptive binarizer.
interface adaptive_binarizer_if;
    import adaptive_thr_pkg::*;

    logic             iValid;
    logic [PIX_W-1:0] iPixel;
    logic             iSof;
    logic             oReady;
    logic             oValid;
    logic             oBin;
    logic             oEol;
    logic             oEof;
    logic             iReady;

    modport slave (
        input  iValid, iPixel, iSof, iReady,
        output oReady, oValid, oBin, oEol, oEof
    );

    modport master (
        output iValid, iPixel, iSof, iReady,
        input  oReady, oValid, oBin, oEol, oEof
    );
endinterface

// File: rtl/binarizer_raster_counter.sv
// Raster column/row counters; reports the address and line/frame flags of the
// pixel transferred this cycle, with start-of-frame forcing (0,0).
module binarizer_raster_counter
    import adaptive_thr_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              xfer,
    input  logic              sof,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] row,
    output logic              eol,
    output logic              eof
);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;

    always_comb begin
        col   = sof ? '0 : col_q;
        row   = sof ? '0 : row_q;
        eol   = (col == COL_LAST);
        eof   = eol && (row == ROW_LAST);
        col_d = col_q;
        row_d = row_q;
        if (xfer) begin
            if (eol) begin
                col_d = '0;
                row_d = (row == ROW_LAST) ? '0 : row + ADDR_W'(1);
            end else begin
                col_d = col + ADDR_W'(1);
                row_d = row;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/adaptive_binarizer.sv
// Two-stage pixel binarizer against a per-pixel threshold ROM read one cycle ahead.
// Optional feature: ADAPTIVE_BINARIZER_OFFSET_EN adds a signed threshold offset port.
module adaptive_binarizer
    import adaptive_thr_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic                 clock,
    input  logic                 reset,
    adaptive_binarizer_if.slave  bus,
    output logic [ADDR_W-1:0]    oCol,
    output logic [ADDR_W-1:0]    oRow,
    input  logic [PIX_W-1:0]     iThreshold
`ifdef ADAPTIVE_BINARIZER_OFFSET_EN
    ,
    input  logic [PIX_W-1:0]     iOffset
`endif
);
    s1_rec_t           s1_q, s1_d;
    logic              ovalid_q, ovalid_d;
    logic              obin_q, obin_d;
    logic              oeol_q, oeol_d;
    logic              oeof_q, oeof_d;
    logic              advance, xfer, sof;
    logic [ADDR_W-1:0] cnt_col, cnt_row;
    logic              cnt_eol, cnt_eof;
    logic [PIX_W-1:0]  eff_thr;

    assign advance = !ovalid_q || bus.iReady;
    assign xfer    = bus.iValid && advance && !reset;
    assign sof     = bus.iValid && bus.iSof;

    binarizer_raster_counter #(.COLS(COLS), .ROWS(ROWS)) u_raster_counter (
        .clock (clock),
        .reset (reset),
        .xfer  (xfer),
        .sof   (sof),
        .col   (cnt_col),
        .row   (cnt_row),
        .eol   (cnt_eol),
        .eof   (cnt_eof)
    );

`ifdef ADAPTIVE_BINARIZER_OFFSET_EN
    assign eff_thr = clamp_thr(iThreshold, iOffset);
`else
    assign eff_thr = iThreshold;
`endif

    // While stalled the ROM keeps being addressed with S1's pixel so that
    // iThreshold still belongs to it when the pipeline moves again.
    always_comb begin
        if (reset) begin
            oCol = '0;
            oRow = '0;
        end else if (advance) begin
            oCol = cnt_col;
            oRow = cnt_row;
        end else begin
            oCol = s1_q.col;
            oRow = s1_q.row;
        end
    end

    always_comb begin
        s1_d     = s1_q;
        ovalid_d = ovalid_q;
        obin_d   = obin_q;
        oeol_d   = oeol_q;
        oeof_d   = oeof_q;
        if (advance) begin
            s1_d.valid = xfer;
            s1_d.pixel = bus.iPixel;
            s1_d.col   = cnt_col;
            s1_d.row   = cnt_row;
            s1_d.eol   = cnt_eol;
            s1_d.eof   = cnt_eof;
            ovalid_d   = s1_q.valid;
            obin_d     = s1_q.valid && (s1_q.pixel > eff_thr);
            oeol_d     = s1_q.valid && s1_q.eol;
            oeof_d     = s1_q.valid && s1_q.eof;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q     <= '0;
            ovalid_q <= 1'b0;
            obin_q   <= 1'b0;
            oeol_q   <= 1'b0;
            oeof_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            ovalid_q <= ovalid_d;
            obin_q   <= obin_d;
            oeol_q   <= oeol_d;
            oeof_q   <= oeof_d;
        end
    end

    assign bus.oReady = advance && !reset;
    assign bus.oValid = ovalid_q;
    assign bus.oBin   = obin_q;
    assign bus.oEol   = oeol_q;
    assign bus.oEof   = oeof_q;
endmodule

// File: tb/tb_adaptive_binarizer.sv
// Randomized bench for adaptive_binarizer: a raster/threshold model predicts every
// output pixel, a registered-read ROM stands in for the threshold reader.
module tb_adaptive_binarizer;
    localparam int COLS = 64;
    localparam int ROWS = 16;

    typedef struct {
        bit bin;
        bit eol;
        bit eof;
        int cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] oCol, oRow, thr;
`ifdef ADAPTIVE_BINARIZER_OFFSET_EN
    logic [7:0] offset = 8'h00;
`endif
    logic [7:0] rom [COLS*ROWS];

    adaptive_binarizer_if bus();

    adaptive_binarizer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .oCol       (oCol),
        .oRow       (oRow),
        .iThreshold (thr)
`ifdef ADAPTIVE_BINARIZER_OFFSET_EN
        ,
        .iOffset    (offset)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) thr <= rom[int'(oRow) * COLS + int'(oCol)];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   mcol = 0, mrow = 0, last_col = 0, last_row = 0;
    bit   hold_pending = 0;
    logic hold_bin, hold_eol, hold_eof;
    bit   check_lat = 0;
    int   n_out = 0, n_eol = 0, n_eof = 0;

    task automatic check_eq(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int eff(input logic [7:0] t);
`ifdef ADAPTIVE_BINARIZER_OFFSET_EN
        int v;
        v = int'(t) - int'($signed(offset));
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
`else
        return int'(t);
`endif
    endfunction

    function automatic logic [7:0] pick_pix(input bit s);
        int c, r;
        c = s ? 0 : mcol;
        r = s ? 0 : mrow;
        if ($urandom_range(0, 3) == 0) return 8'(eff(rom[r * COLS + c]));
        return 8'($urandom_range(0, 255));
    endfunction

    // One clock: drive inputs, check held/stalled/emitted outputs, model any transfer.
    task automatic tick(input bit v, input logic [7:0] pix, input bit sof, input bit rdy);
        exp_t e;
        int   c, r;
        @(negedge clock);
        bus.iValid = v;
        bus.iPixel = pix;
        bus.iSof   = sof;
        bus.iReady = rdy;
        #1;
        if (hold_pending) begin
            check_eq("hold_valid", int'(bus.oValid), 1);
            check_eq("hold_bin", int'(bus.oBin), int'(hold_bin));
            check_eq("hold_eol", int'(bus.oEol), int'(hold_eol));
            check_eq("hold_eof", int'(bus.oEof), int'(hold_eof));
        end
        if (!bus.oReady && exp_q.size() == 2) begin
            check_eq("stall_col", int'(oCol), last_col);
            check_eq("stall_row", int'(oRow), last_row);
        end
        if (bus.oValid && rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("bin", int'(bus.oBin), int'(e.bin));
                check_eq("eol", int'(bus.oEol), int'(e.eol));
                check_eq("eof", int'(bus.oEof), int'(e.eof));
                if (check_lat) check_eq("latency", cyc - e.cyc, 2);
            end
            n_out++;
            n_eol += int'(bus.oEol);
            n_eof += int'(bus.oEof);
        end
        hold_pending = bus.oValid && !rdy;
        hold_bin = bus.oBin;
        hold_eol = bus.oEol;
        hold_eof = bus.oEof;
        if (v && bus.oReady) begin
            c = sof ? 0 : mcol;
            r = sof ? 0 : mrow;
            check_eq("addr_col", int'(oCol), c);
            check_eq("addr_row", int'(oRow), r);
            e.bin = int'(pix) > eff(rom[r * COLS + c]);
            e.eol = (c == COLS - 1);
            e.eof = e.eol && (r == ROWS - 1);
            e.cyc = cyc;
            exp_q.push_back(e);
            last_col = c;
            last_row = r;
            mcol = c + 1;
            mrow = r;
            if (mcol == COLS) begin
                mcol = 0;
                mrow = (r + 1) % ROWS;
            end
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("drained", exp_q.size(), 0);
    endtask

    task automatic stream(input int n, input int sof_at);
        for (int i = 0; i < n; i++) begin
            bit s;
            s = (i == 0) || (i == sof_at);
            tick(1'b1, pick_pix(s), s, 1'b1);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        bus.iValid = 1'b0;
        bus.iSof = 1'b0;
        bus.iReady = 1'b1;
        repeat (n) @(negedge clock);
        #1;
        check_eq("rst_valid", int'(bus.oValid), 0);
        check_eq("rst_bin", int'(bus.oBin), 0);
        check_eq("rst_eol", int'(bus.oEol), 0);
        check_eq("rst_eof", int'(bus.oEof), 0);
        check_eq("rst_col", int'(oCol), 0);
        check_eq("rst_row", int'(oRow), 0);
        reset = 1'b0;
        #1;
        check_eq("rst_ready", int'(bus.oReady), 1);
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        hold_pending = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.iValid = 1'b0;
        bus.iPixel = 8'h00;
        bus.iSof   = 1'b0;
        bus.iReady = 1'b1;
        for (int i = 0; i < COLS * ROWS; i++) rom[i] = 8'h80;
        do_reset(3);

        // Flat 0x80 ROM: strict compare around the threshold, fixed two-cycle latency.
        check_lat = 1;
        tick(1'b1, 8'h7F, 1'b1, 1'b1);
        tick(1'b1, 8'h80, 1'b0, 1'b1);
        tick(1'b1, 8'h81, 1'b0, 1'b1);
        drain();

`ifdef ADAPTIVE_BINARIZER_OFFSET_EN
        offset = 8'h10;
        rom[0] = 8'h05;
        rom[1] = 8'h05;
        tick(1'b1, 8'h00, 1'b1, 1'b1);
        tick(1'b1, 8'h01, 1'b0, 1'b1);
        drain();
        offset = 8'hF0;
        rom[0] = 8'hF8;
        tick(1'b1, 8'hFF, 1'b1, 1'b1);
        drain();
        offset = 8'($urandom_range(0, 255));
`endif

        for (int i = 0; i < COLS * ROWS; i++) rom[i] = 8'($urandom_range(0, 255));

        // Stall five cycles right after pixel (17,3) is accepted.
        stream(3 * COLS + 18, -1);
        check_lat = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, pick_pix(1'b0), 1'b0, 1'b0);
            check_eq("stall17_col", int'(oCol), 17);
            check_eq("stall17_row", int'(oRow), 3);
        end
        stream(4, -1);
        drain();

        // Start-of-frame arriving mid-frame at (40,9).
        check_lat = 1;
        stream(9 * COLS + 45, 9 * COLS + 40);
        drain();

        // Randomized valid/ready/sof traffic.
        check_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v, s, rd;
            v  = $urandom_range(0, 3) != 0;
            s  = $urandom_range(0, 199) == 0;
            rd = $urandom_range(0, 9) < 7;
            tick(v, pick_pix(s), s, rd);
        end
        drain();

        // One whole frame back to back, then counters must have wrapped to (0,0).
        check_lat = 1;
        n_out = 0;
        n_eol = 0;
        n_eof = 0;
        stream(COLS * ROWS, -1);
        drain();
        check_eq("frame_outputs", n_out, COLS * ROWS);
        check_eq("frame_eol_count", n_eol, ROWS);
        check_eq("frame_eof_count", n_eof, 1);
        tick(1'b1, pick_pix(1'b0), 1'b0, 1'b1);
        drain();

        // Reset while both stages are full.
        check_lat = 0;
        tick(1'b1, pick_pix(1'b0), 1'b0, 1'b1);
        tick(1'b1, pick_pix(1'b0), 1'b0, 1'b1);
        tick(1'b1, pick_pix(1'b0), 1'b0, 1'b0);
        do_reset(1);
        tick(1'b1, pick_pix(1'b0), 1'b0, 1'b1);
        tick(1'b1, pick_pix(1'b0), 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adaptive_binarizer.md
ADAPTIVE_BINARIZER -- requirements
Module: adaptive_binarizer

Interface
REQ-001 Parameter COLS, default 256, pixels per line (1..256).
REQ-002 Parameter ROWS, default 256, lines per frame (1..256).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iValid  input  1  upstream pixel valid.
REQ-006 iPixel  input  8  upstream grayscale pixel, unsigned.
REQ-007 iSof  input  1  start of frame; qualified by iValid, marks pixel (0,0).
REQ-008 oReady  output  1  block can accept a pixel this cycle.
REQ-009 oCol  output  8  column address to threshold_rom_reader.iCol.
REQ-010 oRow  output  8  row address to threshold_rom_reader.iRow.
REQ-011 iThreshold  input  8  threshold_rom_reader.oData; equals ROM[oCol,oRow] as presented one cycle earlier.
REQ-012 oValid  output  1  output pixel valid.
REQ-013 oBin  output  1  binarized pixel.
REQ-014 oEol  output  1  output pixel is last of its line.
REQ-015 oEof  output  1  output pixel is last of frame.
REQ-016 iReady  input  1  downstream accepts output when high.
REQ-017 iOffset  input  8  signed threshold offset (only with ADAPTIVE_BINARIZER_OFFSET_EN).

Function
REQ-018 Input transfer occurs when iValid && oReady; output transfer when oValid && iReady.
REQ-019 Pipeline is two stages: S1 (pixel, address, flags), S2 (output registers); advance = !oValid || iReady; oReady = advance.
REQ-020 On advance: S1 loads the transferred input (or becomes empty); S2 loads S1 result (or becomes empty).
REQ-021 oCol/oRow = raster counters when advance is high, else S1's stored address, so iThreshold always matches S1 while stalled.
REQ-022 Latency: pixel accepted at cycle t appears on oValid at t+2 with no backpressure; throughput one pixel per cycle.
REQ-023 oBin = 1 iff S1 pixel > effective threshold (strict); pixel equal to threshold gives 0.
REQ-024 Raster counters: col increments per input transfer; at COLS-1 wraps to 0 and row increments; row wraps ROWS-1 -> 0.
REQ-025 iSof on a transfer forces that pixel's address to (0,0), counters continue from (1,0).
REQ-026 oEol = (col == COLS-1), oEof = oEol && (row == ROWS-1), both carried with the pixel through S1/S2.
REQ-027 Outputs hold stable while oValid && !iReady.
REQ-028 No pixel dropped or duplicated under any iValid/iReady pattern.

Reset
REQ-029 During reset: oValid=0, oBin=0, oEol=0, oEof=0, S1 empty, counters (0,0), oCol=0, oRow=0.
REQ-030 oReady is 1 in the first cycle after reset is released.
REQ-031 Reset mid-frame discards S1/S2 contents; next accepted pixel is (0,0).

Configuration
REQ-032 Macro ADAPTIVE_BINARIZER_OFFSET_EN defined: effective threshold = clamp(iThreshold - iOffset, 0, 255), iOffset signed, computed in 10-bit signed arithmetic.
REQ-033 Macro undefined: iOffset port absent, effective threshold = iThreshold.

Structure
REQ-034 Shared package adaptive_thr_pkg holds pixel width (8), address width (8), default COLS/ROWS, and the S1 stage record typedef.
REQ-035 Sub-module binarizer_raster_counter (col/row counters, iSof, wrap, eol/eof) is instantiated once.
REQ-036 Top level connects oCol/oRow/iThreshold directly to one threshold_rom_reader instance; no extra register in between.

Verification
REQ-037 Reset, ROM all 0x80, stream 0x7F,0x80,0x81 with iReady=1 -> oBin 0,0,1 at cycles t+2..t+4.
REQ-038 Full 256x256 frame, iReady=1 -> 65536 outputs, oEol on every 256th, oEof only on last, counters back to (0,0).
REQ-039 iReady low 5 cycles mid-line at pixel (17,3) -> oCol/oRow held 17/3, oBin matches ROM[17,3] reference after release, no loss.
REQ-040 iSof asserted at pixel (40,9) -> that pixel uses address (0,0), next uses (1,0).
REQ-041 OFFSET_EN, iThreshold 0x05, iOffset 0x10 -> effective 0; iThreshold 0xF8, iOffset 0xF0 (-16) -> effective 255; pixel 0xFF -> oBin 0.
REQ-042 reset pulsed with S1 and S2 full -> oValid 0 next cycle, first post-reset output has address (0,0).
